// File: rtl/prog_counter.sv
// prog_counter: programmable up/down counter with terminal value MAX,
// wrap or saturate behaviour, parallel load and an enable prescaler.
// With default parameters and up=1 it behaves as a free-running 18-bit
// up-counter. Includes a small companion checker for parameter legality
// and output invariants.

module prog_counter_chk #(
  parameter int WIDTH    = 18,
  parameter int MAX      = 262143,
  parameter int PRESCALE = 1
) (
  input logic             clk,
  input logic             rst,
  input logic [WIDTH-1:0] cntr,
  input logic             wrap
);
  // Largest value representable in WIDTH bits, computed in 64-bit signed.
  localparam longint LIMIT = (WIDTH >= 63) ? 64'sh7FFF_FFFF_FFFF_FFFF
                                           : ((64'sd1 <<< WIDTH) - 64'sd1);
  localparam bit PARAMS_OK = (WIDTH >= 1) && (MAX >= 1) &&
                             (longint'(MAX) <= LIMIT) && (PRESCALE >= 1);
  localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] ZERO_V = {WIDTH{1'b0}};

  if (!PARAMS_OK) begin : g_param_err
    $error("prog_counter: illegal parameters WIDTH=%0d MAX=%0d PRESCALE=%0d",
           WIDTH, MAX, PRESCALE);
  end

  // Parameters must describe a legal counter for the whole run.
  a_params: assert property (@(posedge clk) PARAMS_OK);

  // The count never leaves the range 0..MAX.
  a_cntr_range: assert property (@(posedge clk) disable iff (!rst)
                                 (cntr <= MAX_V));

  // A wrap pulse is only ever shown alongside one of the two end values.
  a_wrap_value: assert property (@(posedge clk) disable iff (!rst)
                                 wrap |-> ((cntr == ZERO_V) || (cntr == MAX_V)));
endmodule

module prog_counter #(
  parameter int WIDTH    = 18,
  parameter int MAX      = 262143,
  parameter int PRESCALE = 1,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] cntr,
  output logic             tc,
  output logic             wrap
);
  // Prescaler needs clog2(PRESCALE) bits, but never fewer than one.
  localparam int               PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] MAX_V    = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] ZERO_V   = {WIDTH{1'b0}};
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [PRE_W-1:0] PRE_ZERO = {PRE_W{1'b0}};
  localparam logic             SAT      = (SATURATE != 0);

  logic [WIDTH-1:0] r_cntr;
  logic [PRE_W-1:0] r_pre;
  logic             r_wrap;

  logic [WIDTH-1:0] w_load_val;
  logic [WIDTH-1:0] w_cntr_nxt;
  logic [PRE_W-1:0] w_pre_nxt;
  logic             w_wrap_nxt;
  logic             w_step;
  logic             w_at_max;
  logic             w_at_zero;

  // End-of-range detection, step qualification and load-value clamping.
  always_comb begin
    w_at_max  = (r_cntr == MAX_V);
    w_at_zero = (r_cntr == ZERO_V);
    w_step    = en && (r_pre == PRE_LAST);
    if (din > MAX_V) begin
      w_load_val = MAX_V;
    end else begin
      w_load_val = din;
    end
  end

  // Prescaler advance: load restarts the period, a completed period
  // restarts it too, otherwise each enabled edge moves it one further.
  always_comb begin
    w_pre_nxt = r_pre;
    if (load) begin
      w_pre_nxt = PRE_ZERO;
    end else if (w_step) begin
      w_pre_nxt = PRE_ZERO;
    end else if (en) begin
      w_pre_nxt = r_pre + PRE_W'(1'b1);
    end else begin
      w_pre_nxt = r_pre;
    end
  end

  // Next count and wrap pulse; load discards any coincident step.
  always_comb begin
    w_cntr_nxt = r_cntr;
    w_wrap_nxt = 1'b0;
    if (load) begin
      w_cntr_nxt = w_load_val;
      w_wrap_nxt = 1'b0;
    end else if (w_step && up) begin
      if (!w_at_max) begin
        w_cntr_nxt = r_cntr + WIDTH'(1'b1);
      end else if (SAT) begin
        w_cntr_nxt = MAX_V;
      end else begin
        w_cntr_nxt = ZERO_V;
        w_wrap_nxt = 1'b1;
      end
    end else if (w_step) begin
      if (!w_at_zero) begin
        w_cntr_nxt = r_cntr - WIDTH'(1'b1);
      end else if (SAT) begin
        w_cntr_nxt = ZERO_V;
      end else begin
        w_cntr_nxt = MAX_V;
        w_wrap_nxt = 1'b1;
      end
    end else begin
      w_cntr_nxt = r_cntr;
      w_wrap_nxt = 1'b0;
    end
  end

  // State registers with synchronous active-low reset overriding everything.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cntr <= ZERO_V;
      r_pre  <= PRE_ZERO;
      r_wrap <= 1'b0;
    end else begin
      r_cntr <= w_cntr_nxt;
      r_pre  <= w_pre_nxt;
      r_wrap <= w_wrap_nxt;
    end
  end

  assign cntr = r_cntr;
  assign wrap = r_wrap;
  // Terminal count follows the live direction input, not a registered copy.
  assign tc   = (up && (r_cntr == MAX_V)) || (!up && (r_cntr == ZERO_V));

  prog_counter_chk #(
    .WIDTH    (WIDTH),
    .MAX      (MAX),
    .PRESCALE (PRESCALE)
  ) u_chk (
    .clk  (clk),
    .rst  (rst),
    .cntr (r_cntr),
    .wrap (r_wrap)
  );
endmodule
